// File: rtl/dram_fifo64_ctrl_if.sv
// Bus bundle between the FIFO controller, its user and the external 64x1 distributed RAM.
interface dram_fifo64_ctrl_if #(
  parameter int unsigned DATA_W = 8
);
  localparam int unsigned PTR_W = 6;
  localparam int unsigned LVL_W = 7;

  // user side
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic [LVL_W-1:0]  level;
  logic              ovf;
  logic              udf;
  logic              clr_err;

  // RAM side
  logic              ram_we;
  logic [PTR_W-1:0]  ram_a;
  logic [PTR_W-1:0]  ram_dpra;
  logic [DATA_W-1:0] ram_d;
  logic [DATA_W-1:0] ram_dpo;

  modport slave (
    input  wr_en, wr_data, rd_en, clr_err, ram_dpo,
    output rd_data, full, empty, almost_full, level, ovf, udf,
           ram_we, ram_a, ram_dpra, ram_d
  );

  modport master (
    output wr_en, wr_data, rd_en, clr_err, ram_dpo,
    input  rd_data, full, empty, almost_full, level, ovf, udf,
           ram_we, ram_a, ram_dpra, ram_d
  );
endinterface

// File: rtl/dram_fifo64_ctrl.sv
// 64-deep first-word-fall-through FIFO controller; all storage lives in an
// external 64xDATA_W dual-port distributed RAM, this block only keeps pointers,
// occupancy and flags.
module dram_fifo64_ctrl #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned AF_THRESH = 48
) (
  input logic                  clk,
  input logic                  rst,
  dram_fifo64_ctrl_if.slave    bus
);
  localparam int unsigned PTR_W = 6;
  localparam int unsigned LVL_W = 7;
  localparam int unsigned DEPTH = 64;

  logic [PTR_W-1:0] wptr, wptr_nx;
  logic [PTR_W-1:0] rptr, rptr_nx;
  logic [LVL_W-1:0] level, level_nx;
  logic             full, full_nx;
  logic             empty, empty_nx;
  logic             af, af_nx;
  logic             ovf, ovf_nx;
  logic             udf, udf_nx;
  logic             wr_ok;
  logic             rd_ok;

  // Accept decisions use the current registered flags; nothing is accepted while in reset.
  assign wr_ok = bus.wr_en & ~full  & ~rst;
  assign rd_ok = bus.rd_en & ~empty & ~rst;

  // RAM hookup: write port driven straight from the request, read data falls through.
  assign bus.ram_we   = wr_ok;
  assign bus.ram_d    = DATA_W'(bus.wr_data);
  assign bus.ram_a    = wptr;
  assign bus.ram_dpra = rptr;
  assign bus.rd_data  = DATA_W'(bus.ram_dpo);

  assign bus.level       = level;
  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.almost_full = af;
  assign bus.ovf         = ovf;
  assign bus.udf         = udf;

  // Next-state: pointers, occupancy, flags derived from the post-edge level, sticky errors.
  always_comb begin
    wptr_nx  = wptr;
    rptr_nx  = rptr;
    level_nx = level;
    ovf_nx   = ovf;
    udf_nx   = udf;

    if (wr_ok) wptr_nx = wptr + PTR_W'(1);
    if (rd_ok) rptr_nx = rptr + PTR_W'(1);

    if (wr_ok && !rd_ok)      level_nx = level + LVL_W'(1);
    else if (rd_ok && !wr_ok) level_nx = level - LVL_W'(1);

    full_nx  = (level_nx == LVL_W'(DEPTH));
    empty_nx = (level_nx == LVL_W'(0));
    af_nx    = (level_nx >= LVL_W'(AF_THRESH));

    // a set condition on the same edge beats a clear request
    if (bus.wr_en && full)   ovf_nx = 1'b1;
    else if (bus.clr_err)    ovf_nx = 1'b0;
    if (bus.rd_en && empty)  udf_nx = 1'b1;
    else if (bus.clr_err)    udf_nx = 1'b0;
  end

  // State registers with asynchronous reset to the empty queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
      af    <= 1'b0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      wptr  <= wptr_nx;
      rptr  <= rptr_nx;
      level <= level_nx;
      full  <= full_nx;
      empty <= empty_nx;
      af    <= af_nx;
      ovf   <= ovf_nx;
      udf   <= udf_nx;
    end
  end
endmodule

// File: tb/tb_dram_fifo64_ctrl.sv
// Bench for dram_fifo64_ctrl: external RAM model, queue scoreboard, vector table
// and directed sequences for fill/overflow, full-bypass, streaming and async reset.
module tb_dram_fifo64_ctrl;
  localparam int unsigned DW = 8;
  localparam int AF = 48;

  logic clk;
  logic rst;

  dram_fifo64_ctrl_if #(.DATA_W(DW)) bus();

  dram_fifo64_ctrl #(.DATA_W(DW), .AF_THRESH(AF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // external distributed RAM: synchronous write, asynchronous dual-port read
  logic [DW-1:0] mem [64];
  always @(posedge clk) if (bus.ram_we) mem[bus.ram_a] <= bus.ram_d;
  assign bus.ram_dpo = mem[bus.ram_dpra];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] q[$];
  logic m_ovf, m_udf;

  typedef struct {
    logic          wr;
    logic          rd;
    logic          clr;
    logic [DW-1:0] d;
    int            lvl;
    logic          emp;
    logic          ovf;
    logic          udf;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock of stimulus, called at posedge+1; checks fall-through data before the edge
  // and level/flags after it against the queue model.
  task automatic cycle(input logic wr, input logic [DW-1:0] d, input logic rd, input logic clr);
    int  sz;
    logic wacc, racc;
    bus.wr_en = wr; bus.wr_data = d; bus.rd_en = rd; bus.clr_err = clr;
    #1;
    sz   = q.size();
    racc = rd && (sz > 0);
    wacc = wr && (sz < 64);
    if (racc) chk("rd_data", int'(bus.rd_data), int'(q[0]));
    chk("ram_we", int'(bus.ram_we), int'(wacc));
    if (racc) void'(q.pop_front());
    if (wacc) q.push_back(d);
    if (wr && sz == 64) m_ovf = 1'b1; else if (clr) m_ovf = 1'b0;
    if (rd && sz == 0)  m_udf = 1'b1; else if (clr) m_udf = 1'b0;
    @(posedge clk); #1;
    chk("level", int'(bus.level), q.size());
    chk("full",  int'(bus.full),  int'(q.size() == 64));
    chk("empty", int'(bus.empty), int'(q.size() == 0));
    chk("almost_full", int'(bus.almost_full), int'(q.size() >= AF));
    chk("ovf", int'(bus.ovf), int'(m_ovf));
    chk("udf", int'(bus.udf), int'(m_udf));
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.clr_err = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.clr_err = 1'b0; bus.wr_data = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    m_ovf = 1'b0; m_udf = 1'b0;
  endtask

  initial begin
    tbl[0] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b1}; // pop empty -> udf
    tbl[1] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 1'b0}; // clear
    tbl[2] = '{1'b1, 1'b0, 1'b0, 8'hA5, 1, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 8'h11, 1, 1'b0, 1'b0, 1'b0}; // both, level held
    tbl[4] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 8'h22, 1, 1'b0, 1'b0, 1'b1}; // both on empty
    tbl[6] = '{1'b0, 1'b1, 1'b1, 8'h00, 0, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 8'h00, 0, 1'b1, 1'b0, 1'b1}; // set beats clear
    tbl[8] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 1'b0};

    rst = 1'b1;
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.clr_err = 1'b0; bus.wr_data = '0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_level", int'(bus.level), 0);
    chk("rst_empty", int'(bus.empty), 1);
    chk("rst_full",  int'(bus.full), 0);
    chk("rst_af",    int'(bus.almost_full), 0);
    chk("rst_ovf",   int'(bus.ovf), 0);
    chk("rst_udf",   int'(bus.udf), 0);
    chk("rst_ram_a", int'(bus.ram_a), 0);
    chk("rst_dpra",  int'(bus.ram_dpra), 0);
    rst = 1'b0;
    q.delete(); m_ovf = 1'b0; m_udf = 1'b0;

    // vector table
    for (int i = 0; i < 9; i++) begin
      cycle(tbl[i].wr, tbl[i].d, tbl[i].rd, tbl[i].clr);
      chk($sformatf("tbl%0d_level", i), int'(bus.level), tbl[i].lvl);
      chk($sformatf("tbl%0d_empty", i), int'(bus.empty), int'(tbl[i].emp));
      chk($sformatf("tbl%0d_ovf", i),   int'(bus.ovf),   int'(tbl[i].ovf));
      chk($sformatf("tbl%0d_udf", i),   int'(bus.udf),   int'(tbl[i].udf));
    end

    // single write fall-through
    do_reset();
    cycle(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("ft_empty", int'(bus.empty), 0);
    chk("ft_level", int'(bus.level), 1);
    chk("ft_rd_data", int'(bus.rd_data), 8'hA5);
    chk("ft_ram_a", int'(bus.ram_a), 1);
    chk("ft_dpra", int'(bus.ram_dpra), 0);

    // fill to full, almost-full threshold, wrap, overflow
    do_reset();
    for (int i = 0; i < 64; i++) begin
      cycle(1'b1, 8'(i), 1'b0, 1'b0);
      chk($sformatf("fill_af_%0d", i + 1), int'(bus.almost_full), int'(i + 1 >= 48));
    end
    chk("fill_full", int'(bus.full), 1);
    chk("fill_level", int'(bus.level), 64);
    chk("fill_ram_a", int'(bus.ram_a), 0);
    cycle(1'b1, 8'hEE, 1'b0, 1'b0);
    chk("ovf_set", int'(bus.ovf), 1);
    chk("ovf_level", int'(bus.level), 64);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_clr", int'(bus.ovf), 0);
    // write+read while full: read wins, overflow flagged
    cycle(1'b1, 8'hEF, 1'b1, 1'b0);
    chk("fb_level", int'(bus.level), 63);
    chk("fb_full", int'(bus.full), 0);
    chk("fb_ovf", int'(bus.ovf), 1);
    chk("fb_rd_data", int'(bus.rd_data), 8'h01);

    // continuous streaming at level 10
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    for (int i = 0; i < 200; i++) cycle(1'b1, 8'(i * 7 + 3), 1'b1, 1'b0);
    chk("stream_level", int'(bus.level), 10);
    chk("stream_ram_a", int'(bus.ram_a), (210 % 64));
    chk("stream_dpra", int'(bus.ram_dpra), (200 % 64));
    for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("drain_empty", int'(bus.empty), 1);

    // asynchronous reset between edges at level 30
    do_reset();
    for (int i = 0; i < 30; i++) cycle(1'b1, 8'(i + 100), 1'b0, 1'b0);
    chk("pre_arst_level", int'(bus.level), 30);
    bus.wr_en = 1'b1; bus.wr_data = 8'h5A;
    #2 rst = 1'b1;
    #1;
    chk("arst_level", int'(bus.level), 0);
    chk("arst_empty", int'(bus.empty), 1);
    chk("arst_af", int'(bus.almost_full), 0);
    chk("arst_ram_a", int'(bus.ram_a), 0);
    chk("arst_dpra", int'(bus.ram_dpra), 0);
    chk("arst_ram_we", int'(bus.ram_we), 0);
    @(posedge clk); #1;
    chk("arst_no_wr", int'(bus.level), 0);
    rst = 1'b0; bus.wr_en = 1'b0;
    q.delete(); m_ovf = 1'b0; m_udf = 1'b0;
    cycle(1'b1, 8'h3C, 1'b0, 1'b0);
    chk("post_arst_data", int'(bus.rd_data), 8'h3C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dram_fifo64_ctrl.md
DRAM_FIFO64_CTRL -- requirements
Module: dram_fifo64_ctrl

Interface
REQ-001 Parameter DATA_W, default 8: data width, equal to the number of parallel 64x1 dual-port distributed-RAM bits driven.
REQ-002 Parameter AF_THRESH, default 48: ALMOST_FULL assertion level, legal range 1..64.
REQ-003 CLK  input  1  single clock; all state updates occur on its rising edge; the RAM write clock is tied to CLK.
REQ-004 RST  input  1  asynchronous, active-high reset.
REQ-005 WR_EN  input  1  write request.
REQ-006 WR_DATA  input  DATA_W  write data.
REQ-007 RD_EN  input  1  read request (pop).
REQ-008 RD_DATA  output  DATA_W  head-of-queue data (first-word fall-through), valid when EMPTY=0.
REQ-009 FULL, EMPTY, ALMOST_FULL  output  1 each  status flags.
REQ-010 LEVEL  output  7  current occupancy, 0..64.
REQ-011 OVF, UDF  output  1 each  sticky overflow/underflow error flags.
REQ-012 CLR_ERR  input  1  synchronous clear of OVF/UDF.
REQ-013 RAM_WE  output  1  RAM write enable.
REQ-014 RAM_A  output  6  RAM write/read address (write pointer).
REQ-015 RAM_DPRA  output  6  RAM dual-port read address (read pointer).
REQ-016 RAM_D  output  DATA_W  RAM data in.
REQ-017 RAM_DPO  input  DATA_W  RAM dual-port asynchronous read data.

Function
REQ-018 Storage depth shall be exactly 64 entries, held entirely in the external RAM; the block holds no data registers.
REQ-019 Write accepted (wr_ok) iff WR_EN=1 and FULL=0; read accepted (rd_ok) iff RD_EN=1 and EMPTY=0, both evaluated on current-cycle flag values.
REQ-020 RAM_WE shall equal wr_ok combinationally; RAM_D shall equal WR_DATA combinationally.
REQ-021 RAM_A shall equal the 6-bit write pointer; RAM_DPRA the 6-bit read pointer; RD_DATA shall equal RAM_DPO combinationally.
REQ-022 Write pointer increments by 1 modulo 64 on wr_ok; read pointer increments by 1 modulo 64 on rd_ok; 63 wraps to 0.
REQ-023 LEVEL: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither.
REQ-024 FULL, EMPTY, ALMOST_FULL shall be registered, reflecting the post-edge LEVEL in the same cycle LEVEL updates: FULL=(LEVEL==64), EMPTY=(LEVEL==0), ALMOST_FULL=(LEVEL>=AF_THRESH).
REQ-025 Written data shall be visible on RD_DATA the cycle after the write when the FIFO was empty (one-cycle write-to-read latency).
REQ-026 Simultaneous WR_EN and RD_EN while FULL: read accepted, write rejected, OVF set, LEVEL becomes 63.
REQ-027 Simultaneous WR_EN and RD_EN while EMPTY: write accepted, read rejected, UDF set, LEVEL becomes 1.
REQ-028 Simultaneous accepted write and read at 0<LEVEL<64: both pointers advance, LEVEL and flags unchanged.
REQ-029 OVF shall set on any edge with WR_EN=1 and FULL=1; UDF on any edge with RD_EN=1 and EMPTY=1; both hold until CLR_ERR or RST.
REQ-030 CLR_ERR with a simultaneous set condition: set wins.

Reset
REQ-031 RST=1 shall immediately force both pointers to 0, LEVEL=0, EMPTY=1, FULL=0, ALMOST_FULL=0, OVF=0, UDF=0, RAM_WE=0.
REQ-032 RST mid-operation discards all queued entries; RAM contents are not cleared and are unobservable until rewritten.
REQ-033 No write or read shall be accepted on an edge while RST=1.

Verification
REQ-034 Reset, write 0xA5 -> next cycle EMPTY=0, LEVEL=1, RD_DATA=0xA5, RAM_A=1, RAM_DPRA=0.
REQ-035 Write 64 words 0x00..0x3F -> FULL=1, LEVEL=64, ALMOST_FULL=1 from 48th write, RAM_A=0 (wrapped); 65th write -> OVF=1, LEVEL stays 64.
REQ-036 From full, WR_EN=RD_EN=1 one cycle -> LEVEL=63, FULL=0, OVF=1, RD_DATA=0x01.
REQ-037 From empty, RD_EN=1 -> UDF=1, LEVEL=0; then CLR_ERR=1 -> UDF=0.
REQ-038 Stream 200 words with WR_EN=RD_EN=1 continuously at LEVEL=10 -> LEVEL stays 10, output order matches input, pointers wrap cleanly.
REQ-039 Assert RST at LEVEL=30 asynchronously between edges -> flags/LEVEL/pointers reset before next edge, EMPTY=1.
